// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, a runtime baud divisor, optional parity and 1/2 stop bits.
// Frames leave LSB first and run back to back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       P_DATA,
    input  logic                        Data_Valid,
    output logic                        ready,
    input  logic                        parity_enable,
    input  logic                        parity_type,
    input  logic                        stop_bits,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    output logic                        TX_OUT,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop, fifo_nonempty;
    logic [DATA_WIDTH-1:0] head;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tx_q, tx_d;
    logic                  bit_done, frame_end, start_next;

    assign fifo_nonempty = (count_q != '0);
    assign ready         = (count_q != CNT_W'(FIFO_DEPTH));
    assign push          = Data_Valid && ready;
    assign head          = mem_q[rd_ptr_q];
    assign bit_done      = (bit_cnt_q == div_q - DIV_WIDTH'(1));

    assign TX_OUT     = tx_q;
    assign busy       = (state_q != IDLE) || fifo_nonempty;
    assign fifo_count = count_q;

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= P_DATA;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // tx_d is the level for the next bit period, so TX_OUT comes straight from a flop.
    always_comb begin
        // NOTE: every combinational output gets a hold/default value first so no latch is inferred.
        state_d    = state_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        frame_end  = 1'b0;
        start_next = 1'b0;
        bit_cnt_d  = '0;
        if (state_q != IDLE) begin
            bit_cnt_d = bit_done ? '0 : bit_cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                start_next = fifo_nonempty;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP1;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
            end
            STOP1: begin
                if (bit_done) begin
                    if (stop2_q) state_d = STOP2;
                    else         frame_end = 1'b1;
                end
            end
            STOP2: begin
                if (bit_done) frame_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            state_d    = IDLE;
            tx_d       = 1'b1;
            start_next = fifo_nonempty;
        end

        // Pop and latch the whole frame configuration in one go.
        if (start_next) begin
            pop       = 1'b1;
            state_d   = START;
            tx_d      = 1'b0;
            bit_cnt_d = '0;
            shift_d   = head;
            par_en_d  = parity_enable;
            par_bit_d = parity_type ? ^head : ~^head;
            stop2_d   = stop_bits;
            div_d     = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= DIV_WIDTH'(1);
            bit_cnt_q <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
        end
    end

endmodule
